// File: rtl/conv_layer_sequencer.sv
// ============================================================================
//  Module      : conv_layer_sequencer
//  Description : Layer-level control sequencer for a convolution unit. Walks
//                output-channel groups (oc) and input-channel groups (ic),
//                loads bias and weights, streams feature-map pixels, drains
//                the ConvUnit pipeline and tracks the result write address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_layer_sequencer #(
  parameter int FM_ADDR_W = 13,   // feature-map address width
  parameter int WM_ADDR_W = 8,    // weight-memory read address width
  parameter int BM_ADDR_W = 9,    // bias-memory read address width
  parameter int GRP_W     = 6,    // channel-group count width
  parameter int PIPE_LAT  = 8     // ConvUnit drain cycles (>=1)
) (
  input  logic                  clk,
  input  logic                  rstn,                 // synchronous, active low
  // control
  input  logic                  start,                // layer start pulse
  input  logic                  stall,                // hold pixel streaming
  input  logic                  Conv_data_valid_out,  // ConvUnit result strobe
  // layer configuration, sampled when start is accepted
  input  logic                  cfg_pw_mode,
  input  logic [3:0]            cfg_scale,
  input  logic [8:0]            cfg_buff_len,
  input  logic [FM_ADDR_W-1:0]  cfg_pix_num,          // pixels per group (>=1)
  input  logic [GRP_W-1:0]      cfg_ic_grp,           // input groups (>=1)
  input  logic [GRP_W-1:0]      cfg_oc_grp,           // output groups (>=1)
  input  logic [FM_ADDR_W-1:0]  cfg_fm_rd_base,
  input  logic [FM_ADDR_W-1:0]  cfg_fm_wr_base,
  // status
  output logic [2:0]            current_state,
  output logic                  state_rst,
  output logic                  busy,
  output logic                  done,
  // ConvUnit control
  output logic                  Conv_data_valid_in,
  output logic                  adder_rst,
  output logic                  bias_out_valid,
  output logic                  PW_mode,
  output logic [3:0]            Conv_scale_in,
  output logic [8:0]            buff_len_ctrl,
  // memory addresses
  output logic [FM_ADDR_W-1:0]  fm_rd_addr,
  output logic [FM_ADDR_W-1:0]  fm_wr_addr,
  output logic [WM_ADDR_W-1:0]  wm_addr_rd,
  output logic [BM_ADDR_W-1:0]  bm_addr_rd
);

  // --------------------------------------------------------------------------
  // State encoding (visible on current_state)
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_BIAS   = 3'd1,
    S_LOAD_WEIGHT = 3'd2,
    S_CONV        = 3'd3,
    S_DRAIN       = 3'd4,
    S_DONE        = 3'd5
  } state_t;

  // Drain counter only needs to reach PIPE_LAT-1
  localparam int             DRN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                 r_state;
  logic                   r_state_rst;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_bias_vld;

  // latched configuration
  logic                   r_pw_mode;
  logic [3:0]             r_scale;
  logic [8:0]             r_buff_len;
  logic [FM_ADDR_W-1:0]   r_pix_num;
  logic [GRP_W-1:0]       r_ic_grp;
  logic [GRP_W-1:0]       r_oc_grp;
  logic [FM_ADDR_W-1:0]   r_rd_base;

  // loop counters and addresses
  logic [FM_ADDR_W-1:0]   r_pix;
  logic [GRP_W-1:0]       r_ic;
  logic [GRP_W-1:0]       r_oc;
  logic [DRN_W-1:0]       r_drain;
  logic [WM_ADDR_W-1:0]   r_wm;
  logic [FM_ADDR_W-1:0]   r_fm_rd;
  logic [FM_ADDR_W-1:0]   r_fm_wr;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  state_t                 w_state_nxt;
  logic                   w_valid_in;
  logic                   w_pix_last;
  logic                   w_ic_last;
  logic                   w_oc_last;
  logic                   w_drn_last;
  logic                   w_start_ok;

  // A pixel is issued on every CONV cycle that is not stalled
  assign w_valid_in = (r_state == S_CONV) && !stall;
  assign w_pix_last = (r_pix == (r_pix_num - FM_ADDR_W'(1)));
  assign w_ic_last  = (r_ic  == (r_ic_grp  - GRP_W'(1)));
  assign w_oc_last  = (r_oc  == (r_oc_grp  - GRP_W'(1)));
  assign w_drn_last = (r_drain == DRN_LAST);
  // start only counts while idle; mid-layer pulses are dropped
  assign w_start_ok = (r_state == S_IDLE) && start;

  // Next-state selection for the layer sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:        if (start) w_state_nxt = S_LOAD_BIAS;
      S_LOAD_BIAS:   w_state_nxt = S_LOAD_WEIGHT;
      S_LOAD_WEIGHT: w_state_nxt = S_CONV;
      S_CONV: begin
        if (w_valid_in && w_pix_last) begin
          w_state_nxt = w_ic_last ? S_DRAIN : S_LOAD_WEIGHT;
        end
      end
      S_DRAIN: begin
        if (w_drn_last) begin
          w_state_nxt = w_oc_last ? S_DONE : S_LOAD_BIAS;
        end
      end
      S_DONE:        w_state_nxt = S_IDLE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus registered status flags derived from the next state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_state_rst <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bias_vld  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_state_rst <= (w_state_nxt != r_state);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_bias_vld  <= (w_state_nxt == S_LOAD_BIAS);
    end
  end

  // Configuration latch, loop counters, read and weight addresses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pw_mode  <= 1'b0;
      r_scale    <= '0;
      r_buff_len <= '0;
      r_pix_num  <= '0;
      r_ic_grp   <= '0;
      r_oc_grp   <= '0;
      r_rd_base  <= '0;
      r_pix      <= '0;
      r_ic       <= '0;
      r_oc       <= '0;
      r_drain    <= '0;
      r_wm       <= '0;
      r_fm_rd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pw_mode  <= cfg_pw_mode;
            r_scale    <= cfg_scale;
            r_buff_len <= cfg_buff_len;
            r_pix_num  <= cfg_pix_num;
            r_ic_grp   <= cfg_ic_grp;
            r_oc_grp   <= cfg_oc_grp;
            r_rd_base  <= cfg_fm_rd_base;
            r_pix      <= '0;
            r_ic       <= '0;
            r_oc       <= '0;
            r_drain    <= '0;
            r_wm       <= '0;
            r_fm_rd    <= cfg_fm_rd_base;
          end
        end
        S_CONV: begin
          // Input groups of one oc are contiguous in the feature map, so the
          // read address simply runs on from one ic group into the next.
          if (w_valid_in) begin
            r_fm_rd <= r_fm_rd + FM_ADDR_W'(1);
            if (w_pix_last) begin
              r_pix <= '0;
              r_wm  <= r_wm + WM_ADDR_W'(1);
              if (!w_ic_last) begin
                r_ic <= r_ic + GRP_W'(1);
              end
            end else begin
              r_pix <= r_pix + FM_ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_drn_last) begin
            r_drain <= '0;
            if (!w_oc_last) begin
              r_oc    <= r_oc + GRP_W'(1);
              r_ic    <= '0;
              r_fm_rd <= r_rd_base;
            end
          end else begin
            r_drain <= r_drain + DRN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result write address: loaded at layer start, advanced per ConvUnit result
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fm_wr <= '0;
    end else if (w_start_ok) begin
      r_fm_wr <= cfg_fm_wr_base;
    end else if (r_busy && Conv_data_valid_out) begin
      r_fm_wr <= r_fm_wr + FM_ADDR_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign current_state      = r_state;
  assign state_rst          = r_state_rst;
  assign busy               = r_busy;
  assign done               = r_done;
  assign bias_out_valid     = r_bias_vld;
  assign Conv_data_valid_in = w_valid_in;
  // accumulator clear rides on the very first pixel of each output channel
  assign adder_rst          = w_valid_in && (r_ic == '0) && (r_pix == '0);
  // configuration is only presented while a layer is in flight
  assign PW_mode            = r_busy & r_pw_mode;
  assign Conv_scale_in      = r_busy ? r_scale    : 4'd0;
  assign buff_len_ctrl      = r_busy ? r_buff_len : 9'd0;
  assign fm_rd_addr         = r_fm_rd;
  assign fm_wr_addr         = r_fm_wr;
  assign wm_addr_rd         = r_wm;
  assign bm_addr_rd         = BM_ADDR_W'(r_oc);

endmodule

`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
// ============================================================================
//  Module      : tb_conv_layer_sequencer
//  Description : Scoreboard bench for conv_layer_sequencer. A sequence-level
//                model expands each layer into its per-cycle state trace and
//                its ordered pixel list; a monitor compares the DUT against
//                both queues.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_conv_layer_sequencer;

  localparam int FMW  = 13;
  localparam int WMW  = 8;
  localparam int BMW  = 9;
  localparam int GW   = 6;
  localparam int PL   = 8;
  localparam int MAXC = 1024;

  logic            clk = 1'b0;
  logic            rstn, start, stall, Conv_data_valid_out;
  logic            cfg_pw_mode;
  logic [3:0]      cfg_scale;
  logic [8:0]      cfg_buff_len;
  logic [FMW-1:0]  cfg_pix_num, cfg_fm_rd_base, cfg_fm_wr_base;
  logic [GW-1:0]   cfg_ic_grp, cfg_oc_grp;
  logic [2:0]      current_state;
  logic            state_rst, busy, done, Conv_data_valid_in, adder_rst;
  logic            bias_out_valid, PW_mode;
  logic [3:0]      Conv_scale_in;
  logic [8:0]      buff_len_ctrl;
  logic [FMW-1:0]  fm_rd_addr, fm_wr_addr;
  logic [WMW-1:0]  wm_addr_rd;
  logic [BMW-1:0]  bm_addr_rd;

  always #5 clk = ~clk;

  conv_layer_sequencer #(
    .FM_ADDR_W(FMW), .WM_ADDR_W(WMW), .BM_ADDR_W(BMW), .GRP_W(GW), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .stall(stall),
    .Conv_data_valid_out(Conv_data_valid_out),
    .cfg_pw_mode(cfg_pw_mode), .cfg_scale(cfg_scale), .cfg_buff_len(cfg_buff_len),
    .cfg_pix_num(cfg_pix_num), .cfg_ic_grp(cfg_ic_grp), .cfg_oc_grp(cfg_oc_grp),
    .cfg_fm_rd_base(cfg_fm_rd_base), .cfg_fm_wr_base(cfg_fm_wr_base),
    .current_state(current_state), .state_rst(state_rst), .busy(busy), .done(done),
    .Conv_data_valid_in(Conv_data_valid_in), .adder_rst(adder_rst),
    .bias_out_valid(bias_out_valid), .PW_mode(PW_mode), .Conv_scale_in(Conv_scale_in),
    .buff_len_ctrl(buff_len_ctrl), .fm_rd_addr(fm_rd_addr), .fm_wr_addr(fm_wr_addr),
    .wm_addr_rd(wm_addr_rd), .bm_addr_rd(bm_addr_rd)
  );

  typedef struct {
    logic [FMW-1:0] addr; logic [WMW-1:0] wm; logic [BMW-1:0] bm; logic ar;
    logic pw; logic [3:0] sc; logic [8:0] bl;
  } pix_t;

  typedef struct {
    logic [2:0] st; logic srst; logic [FMW-1:0] wr;
    logic pw; logic [3:0] sc; logic [8:0] bl;
  } trc_t;

  pix_t pq[$];
  trc_t tq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  bit   stall_pat[MAXC];
  bit   wr_pat[MAXC];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expected pixels and per-cycle trace entries
  always @(negedge clk) begin : mon
    pix_t e;
    trc_t t;
    if (Conv_data_valid_in && mon_en) begin
      chk("pixel_expected", (pq.size() > 0) ? 1 : 0, 1);
      if (pq.size() > 0) begin
        e = pq.pop_front();
        chk("fm_rd_addr", fm_rd_addr, e.addr);
        chk("wm_addr_rd", wm_addr_rd, e.wm);
        chk("bm_addr_rd", bm_addr_rd, e.bm);
        chk("adder_rst", adder_rst, e.ar);
        chk("pix_cfg", {PW_mode, Conv_scale_in, buff_len_ctrl}, {e.pw, e.sc, e.bl});
      end
    end
    if (tq.size() > 0) begin
      t = tq.pop_front();
      chk("current_state", current_state, t.st);
      chk("state_rst", state_rst, t.srst);
      chk("busy", busy, (t.st != 3'd0) ? 1 : 0);
      chk("done", done, (t.st == 3'd5) ? 1 : 0);
      chk("bias_out_valid", bias_out_valid, (t.st == 3'd1) ? 1 : 0);
      chk("fm_wr_addr", fm_wr_addr, t.wr);
      chk("cfg_out", {PW_mode, Conv_scale_in, buff_len_ctrl}, {t.pw, t.sc, t.bl});
      chk("adder_rst_only_with_pixel", adder_rst & ~Conv_data_valid_in, 0);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_state"},   current_state, 0);
    chk({tag, "_srst"},    state_rst, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_done"},    done, 0);
    chk({tag, "_vin"},     Conv_data_valid_in, 0);
    chk({tag, "_addrst"},  adder_rst, 0);
    chk({tag, "_bias"},    bias_out_valid, 0);
    chk({tag, "_cfg"},     {PW_mode, Conv_scale_in, buff_len_ctrl}, 0);
    chk({tag, "_fm_rd"},   fm_rd_addr, 0);
    chk({tag, "_fm_wr"},   fm_wr_addr, 0);
    chk({tag, "_wm"},      wm_addr_rd, 0);
    chk({tag, "_bm"},      bm_addr_rd, 0);
  endtask

  task automatic drive_rand_cfg();
    cfg_pw_mode    = 1'($urandom);
    cfg_scale      = 4'($urandom);
    cfg_buff_len   = 9'($urandom);
    cfg_pix_num    = FMW'($urandom);
    cfg_ic_grp     = GW'($urandom);
    cfg_oc_grp     = GW'($urandom);
    cfg_fm_rd_base = FMW'($urandom);
    cfg_fm_wr_base = FMW'($urandom);
  endtask

  // Runs one layer; entered and left just after a rising edge.
  // smode: 0 no stall, 1 random stall, 2 stall in cycles 5 and 6.
  // wmode: 0 random result strobes, 1 strobes in cycles 2..5.
  task automatic run_layer(input int pix, input int ic, input int oc,
                           input logic [FMW-1:0] rd_base, input logic [FMW-1:0] wr_base,
                           input int smode, input int wmode);
    logic           pw;
    logic [3:0]     sc;
    logic [8:0]     bl;
    int             st_l[$];
    pix_t           pe;
    trc_t           te;
    logic [FMW-1:0] wr_e;
    int             prev;
    bit             finished;
    pw = 1'($urandom); sc = 4'($urandom); bl = 9'($urandom);
    for (int j = 0; j < MAXC; j++) begin
      stall_pat[j] = (smode == 1) ? ($urandom_range(3) == 0) : (smode == 2) ? (j == 5 || j == 6) : 1'b0;
      wr_pat[j]    = (wmode == 1) ? (j >= 2 && j <= 5) : ($urandom_range(9) < 3);
    end
    cfg_pw_mode = pw; cfg_scale = sc; cfg_buff_len = bl;
    cfg_pix_num = FMW'(pix); cfg_ic_grp = GW'(ic); cfg_oc_grp = GW'(oc);
    cfg_fm_rd_base = rd_base; cfg_fm_wr_base = wr_base;
    stall = 1'b0; Conv_data_valid_out = 1'b0; start = 1'b1;
    @(posedge clk);
    // sequence model: entry k of st_l is the state during cycle k+1
    for (int o = 0; o < oc; o++) begin
      st_l.push_back(1);
      for (int i = 0; i < ic; i++) begin
        st_l.push_back(2);
        for (int p = 0; p < pix; p++) begin
          while (stall_pat[st_l.size() + 1] && st_l.size() < MAXC - 16) st_l.push_back(3);
          st_l.push_back(3);
          pe.addr = FMW'(int'(rd_base) + i * pix + p);
          pe.wm   = WMW'(o * ic + i);
          pe.bm   = BMW'(o);
          pe.ar   = (i == 0 && p == 0);
          pe.pw = pw; pe.sc = sc; pe.bl = bl;
          pq.push_back(pe);
        end
      end
      for (int d = 0; d < PL; d++) st_l.push_back(4);
    end
    st_l.push_back(5);
    st_l.push_back(0);
    st_l.push_back(0);
    wr_e = wr_base;
    prev = 0;
    for (int k = 0; k < st_l.size(); k++) begin
      te.st   = 3'(st_l[k]);
      te.srst = (st_l[k] != prev);
      te.wr   = wr_e;
      te.pw   = (st_l[k] != 0) ? pw : 1'b0;
      te.sc   = (st_l[k] != 0) ? sc : 4'd0;
      te.bl   = (st_l[k] != 0) ? bl : 9'd0;
      tq.push_back(te);
      if (wr_pat[k + 1] && st_l[k] != 0) wr_e = wr_e + 1'b1;
      prev = st_l[k];
    end
    finished = 1'b0;
    for (int j = 1; j < MAXC; j++) begin
      #1;
      start = (j == 5);
      if (j == 5) drive_rand_cfg();
      stall = stall_pat[j];
      Conv_data_valid_out = wr_pat[j];
      @(posedge clk);
      if (tq.size() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    chk("layer_finished_in_budget", finished, 1);
    tq.delete();
    #1;
    start = 1'b0; stall = 1'b0; Conv_data_valid_out = 1'b0;
    chk("pixels_left_over", pq.size(), 0);
    pq.delete();
  endtask

  // Reset asserted in the middle of CONV; entered and left just after an edge
  task automatic reset_mid_conv();
    mon_en = 1'b0;
    cfg_pw_mode = 1'b1; cfg_scale = 4'hA; cfg_buff_len = 9'h155;
    cfg_pix_num = 13'd6; cfg_ic_grp = 6'd1; cfg_oc_grp = 6'd1;
    cfg_fm_rd_base = 13'h0123; cfg_fm_wr_base = 13'h0456;
    stall = 1'b0; Conv_data_valid_out = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 4; j++) begin
      #1;
      start = 1'b0;
      Conv_data_valid_out = 1'b1;
      if (j == 4) begin
        rstn = 1'b0;
        @(negedge clk);
        chk("pre_reset_in_conv", current_state, 3);
      end
      @(posedge clk);
    end
    Conv_data_valid_out = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin : wdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [FMW-1:0] rb, wb;
    rstn = 1'b0; start = 1'b0; stall = 1'b0; Conv_data_valid_out = 1'b0;
    drive_rand_cfg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("por");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    mon_en = 1'b1;

    // single group, plain stream
    run_layer(4, 1, 1, 13'h0100, 13'h0200, 0, 0);
    // two ic by two oc: weight index, bias index, adder clears
    run_layer(3, 2, 2, 13'h0040, 13'h0010, 0, 0);
    // two stalled cycles in the middle of a 6-pixel stream
    run_layer(6, 1, 1, 13'h0800, 13'h0000, 2, 0);
    // write address wrap: 8190 -> 8191, 0, 1, 2
    run_layer(2, 1, 1, 13'h0005, 13'd8190, 0, 1);
    // read address wrap across an ic boundary
    run_layer(3, 2, 1, 13'd8188, 13'h0001, 1, 0);
    // reset mid-layer, then start on the first cycle after release
    reset_mid_conv();
    run_layer(2, 2, 2, 13'h0300, 13'h0070, 0, 0);
    // randomized layers
    for (int n = 0; n < 20; n++) begin
      rb = FMW'($urandom);
      wb = FMW'($urandom);
      if (n % 4 == 0) begin
        rb = 13'h1FFC + FMW'($urandom_range(3));
        wb = 13'h1FFD + FMW'($urandom_range(2));
      end
      run_layer($urandom_range(1, 8), $urandom_range(1, 3), $urandom_range(1, 3),
                rb, wb, 1, 0);
    end
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 SHALL have parameter FM_ADDR_W, default 13, feature-map address width.
REQ-002 SHALL have parameter WM_ADDR_W, default 8, weight-memory read address width.
REQ-003 SHALL have parameter BM_ADDR_W, default 9, bias-memory read address width.
REQ-004 SHALL have parameter GRP_W, default 6, channel-group count width.
REQ-005 SHALL have parameter PIPE_LAT, default 8, ConvUnit drain cycles (>=1).
REQ-006 SHALL have ports: clk in 1, single clock; rstn in 1, synchronous active-low reset.
REQ-007 SHALL have ports: start in 1, layer start pulse; stall in 1, hold streaming; Conv_data_valid_out in 1, ConvUnit result strobe.
REQ-008 SHALL have ports: cfg_pw_mode in 1; cfg_scale in 4; cfg_buff_len in 9; cfg_pix_num in FM_ADDR_W, pixels per group (>=1); cfg_ic_grp, cfg_oc_grp in GRP_W, group counts (>=1); cfg_fm_rd_base, cfg_fm_wr_base in FM_ADDR_W.
REQ-009 SHALL have outputs: current_state 3, state_rst 1, busy 1, done 1, Conv_data_valid_in 1, adder_rst 1, bias_out_valid 1, PW_mode 1, Conv_scale_in 4, buff_len_ctrl 9.
REQ-010 SHALL have outputs: fm_rd_addr, fm_wr_addr FM_ADDR_W; wm_addr_rd WM_ADDR_W; bm_addr_rd BM_ADDR_W.

Function
REQ-011 SHALL encode states IDLE=0, LOAD_BIAS=1, LOAD_WEIGHT=2, CONV=3, DRAIN=4, DONE=5 on current_state.
REQ-012 SHALL latch all cfg_* inputs on start accepted in IDLE; start outside IDLE SHALL be ignored.
REQ-013 IDLE->LOAD_BIAS on start; oc and ic counters cleared; fm_wr_addr loaded with cfg_fm_wr_base.
REQ-014 LOAD_BIAS SHALL last 1 cycle: bias_out_valid=1, bm_addr_rd=oc; then LOAD_WEIGHT.
REQ-015 LOAD_WEIGHT SHALL last 1 cycle; wm_addr_rd holds a running weight index (oc*ic_grp+ic), incremented on leaving CONV; then CONV.
REQ-016 CONV SHALL stream pix_num pixels: per non-stalled cycle Conv_data_valid_in=1 and fm_rd_addr=rd_base+ic*pix_num+pix, pix incremented.
REQ-017 When stall=1 in CONV, Conv_data_valid_in SHALL be 0 and pix, fm_rd_addr SHALL hold.
REQ-018 adder_rst SHALL pulse 1 cycle with the first valid pixel of ic==0 for each oc.
REQ-019 After last pixel: ic<ic_grp-1 -> ic+1, LOAD_WEIGHT; else -> DRAIN.
REQ-020 DRAIN SHALL last exactly PIPE_LAT cycles, then oc<oc_grp-1 -> oc+1, ic=0, LOAD_BIAS; else DONE.
REQ-021 DONE SHALL last 1 cycle with done=1, then IDLE.
REQ-022 state_rst SHALL pulse 1 cycle on the first cycle of every newly entered state.
REQ-023 busy SHALL be 1 in all states except IDLE.
REQ-024 fm_wr_addr SHALL increment by 1 on each Conv_data_valid_out=1 while busy, wrapping modulo 2^FM_ADDR_W.
REQ-025 All address arithmetic SHALL wrap modulo its port width; no saturation.
REQ-026 PW_mode, Conv_scale_in, buff_len_ctrl SHALL present latched cfg values while busy, 0 in IDLE.

Reset
REQ-027 rstn=0 at a clock edge SHALL force IDLE and zero every output and counter, including mid-layer.
REQ-028 After rstn release the block SHALL accept start on the next cycle.

Verification
REQ-029 pix=4, ic=1, oc=1, PIPE_LAT=8, no stall -> states 1,2,3x4,4x8,5,0; done at cycle 15 after start; fm_rd_addr base..base+3.
REQ-030 pix=3, ic=2, oc=2 -> wm_addr_rd 0,1,2,3; bm_addr_rd 0,1; adder_rst exactly 2 pulses; fm_rd_addr base+0..5 per oc.
REQ-031 stall high 2 cycles mid-CONV -> Conv_data_valid_in low 2 cycles, address held, total 6 valid for pix=6.
REQ-032 fm_wr_base=8190, 4 Conv_data_valid_out pulses -> fm_wr_addr 8191,0,1,2.
REQ-033 rstn low during CONV -> next cycle current_state=0, all outputs 0; new start runs cleanly.
REQ-034 start asserted while busy -> no effect on sequence or latched cfg.
